// File: rtl/game_step_controller.sv
// game_step_controller: owns the registered 4x4 board, score and win/over flags.
// It drives the external combinational merge unit, registers what comes back,
// spawns tiles from a 16-bit LFSR and evaluates the end-of-move conditions.
//
// state | meaning
// INIT  | post-reset, spawn one tile per cycle until the counter runs out
// IDLE  | waiting for a load or a one-hot move request
// APPLY | merge unit sees the latched direction; take its board and score
// SPAWN | drop one new tile into the board
// CHECK | recompute game_won / game_over
// OVER  | no legal move left; only a load (or rst) leaves
module game_step_controller #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    move_valid,
    input  logic [3:0]              move_dir,
    output logic                    move_ready,
    input  logic                    load_valid,
    input  logic [3:0][3:0][11:0]   load_board,
    output logic [3:0]              merge_dir,
    output logic [3:0][3:0][11:0]   merge_board_in,
    input  logic [3:0][3:0][11:0]   merge_board_out,
    input  logic [19:0]             merge_score,
    output logic [3:0][3:0][11:0]   board,
    output logic [19:0]             score,
    output logic                    game_won,
    output logic                    game_over
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_APPLY, S_SPAWN, S_CHECK, S_OVER
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0][3:0][11:0]   board_q, board_d;
    logic [19:0]             score_q, score_d;
    logic                    won_q, won_d;
    logic                    over_q, over_d;
    logic [3:0]              dir_q, dir_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    loaded_q, loaded_d;
    logic [15:0]             lfsr_q;

    logic [3:0][3:0][11:0]   spawn_board;
    logic                    has_2048;
    logic                    no_moves;
    logic                    dir_onehot;
    logic [20:0]             score_sum;

    // First empty cell scanning upward from lfsr[3:0]; full board is left alone.
    function automatic logic [3:0][3:0][11:0] spawn_tile(
        input logic [3:0][3:0][11:0] b,
        input logic [15:0]           l
    );
        logic [3:0][3:0][11:0] r;
        logic [3:0]            idx;
        logic                  found;
        r     = b;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = l[3:0] + 4'(k);
            if (!found && r[idx[3:2]][idx[1:0]] == 12'd0) begin
                r[idx[3:2]][idx[1:0]] = (l[7:4] == 4'd0) ? 12'd4 : 12'd2;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Board evaluation used by CHECK: win tile present, and dead-board detection.
    always_comb begin
        has_2048 = 1'b0;
        no_moves = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board_q[r][c] == 12'd2048) has_2048 = 1'b1;
                if (board_q[r][c] == 12'd0)    no_moves = 1'b0;
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (board_q[r][c] == board_q[r][c+1]) no_moves = 1'b0;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board_q[r][c] == board_q[r+1][c]) no_moves = 1'b0;
            end
        end
    end

    assign spawn_board = spawn_tile(board_q, lfsr_q);
    assign dir_onehot  = (move_dir == 4'b0001) || (move_dir == 4'b0010) ||
                         (move_dir == 4'b0100) || (move_dir == 4'b1000);
    assign score_sum   = {1'b0, score_q} + {1'b0, merge_score};

    // Tile LFSR: Fibonacci, taps 16,14,13,11, free-running outside reset.
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            board_q  <= '0;
            score_q  <= '0;
            won_q    <= 1'b0;
            over_q   <= 1'b0;
            dir_q    <= 4'b0000;
            cnt_q    <= 2'd2;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            score_q  <= score_d;
            won_q    <= won_d;
            over_q   <= over_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

    // Next-state and datapath updates; a load always beats a move.
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        score_d  = score_q;
        won_d    = won_q;
        over_d   = over_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        case (state_q)
            S_INIT: begin
                board_d = spawn_board;
                cnt_d   = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (load_valid) begin
                    board_d  = load_board;
                    loaded_d = 1'b1;
                    state_d  = S_CHECK;
                end else if (move_valid && dir_onehot) begin
                    dir_d   = move_dir;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (merge_board_out == board_q) begin
                    state_d = S_IDLE;
                end else begin
                    board_d = merge_board_out;
                    score_d = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
                    state_d = S_SPAWN;
                end
            end
            S_SPAWN: begin
                board_d = spawn_board;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // A loaded board replaces history, so the win flag is not sticky across it.
                won_d    = has_2048 | (won_q & ~loaded_q);
                over_d   = no_moves;
                loaded_d = 1'b0;
                state_d  = no_moves ? S_OVER : S_IDLE;
            end
            S_OVER: begin
                if (load_valid) begin
                    board_d  = load_board;
                    loaded_d = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    assign move_ready     = (state_q == S_IDLE);
    assign merge_dir      = (state_q == S_APPLY) ? dir_q : 4'b0000;
    assign merge_board_in = board_q;
    assign board          = board_q;
    assign score          = score_q;
    assign game_won       = won_q;
    assign game_over      = over_q;

endmodule

// File: tb/tb_game_step_controller.sv
// Directed bench for game_step_controller. A behavioural slide/merge unit sits
// on the merge ports; a reference LFSR and board model predict every result,
// which is queued when the stimulus is driven and compared when it appears.
module tb_game_step_controller;

    typedef logic [3:0][3:0][11:0] brd_t;
    typedef struct packed {
        brd_t        b;
        logic [19:0] s;
    } mres_t;
    typedef struct {
        string        tag;
        logic [191:0] val;
    } exp_t;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_valid;
    logic [3:0]  move_dir;
    logic        move_ready;
    logic        load_valid;
    brd_t        load_board;
    logic [3:0]  merge_dir;
    brd_t        merge_board_in;
    brd_t        merge_board_out;
    logic [19:0] merge_score;
    brd_t        board;
    logic [19:0] score;
    logic        game_won;
    logic        game_over;

    game_step_controller #(.LFSR_SEED(SEED)) dut (
        .clk             (clk),
        .rst             (rst),
        .move_valid      (move_valid),
        .move_dir        (move_dir),
        .move_ready      (move_ready),
        .load_valid      (load_valid),
        .load_board      (load_board),
        .merge_dir       (merge_dir),
        .merge_board_in  (merge_board_in),
        .merge_board_out (merge_board_out),
        .merge_score     (merge_score),
        .board           (board),
        .score           (score),
        .game_won        (game_won),
        .game_over       (game_over)
    );

    always #5 clk = ~clk;

    // ---------------- reference models ----------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic brd_t ref_spawn(input brd_t b, input logic [15:0] l);
        brd_t r = b;
        int   s = int'(l[3:0]);
        for (int k = 0; k < 16; k++) begin
            int idx = (s + k) % 16;
            if (r[idx/4][idx%4] == 12'd0) begin
                r[idx/4][idx%4] = (l[7:4] == 4'd0) ? 12'd4 : 12'd2;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic is_dead(input brd_t b);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (b[r][c] == 12'd0) return 1'b0;
                if (c < 3 && b[r][c] == b[r][c+1]) return 1'b0;
                if (r < 3 && b[r][c] == b[r+1][c]) return 1'b0;
            end
        return 1'b1;
    endfunction

    function automatic logic has_win(input brd_t b);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == 12'd2048) return 1'b1;
        return 1'b0;
    endfunction

    // Standard 2048 slide: compact toward the move side, merge each pair once.
    function automatic mres_t ref_merge(input brd_t b, input logic [3:0] dir);
        mres_t       r;
        logic [11:0] ln [4];
        logic [11:0] t  [4];
        logic [11:0] o  [4];
        int          n, i, k;
        r.b = b;
        r.s = '0;
        if (!(dir == 4'b0001 || dir == 4'b0010 || dir == 4'b0100 || dir == 4'b1000))
            return r;
        for (int L = 0; L < 4; L++) begin
            for (int j = 0; j < 4; j++) begin
                case (dir)
                    4'b0100: ln[j] = b[L][j];
                    4'b1000: ln[j] = b[L][3-j];
                    4'b0001: ln[j] = b[j][L];
                    default: ln[j] = b[3-j][L];
                endcase
                t[j] = '0;
                o[j] = '0;
            end
            n = 0;
            for (int j = 0; j < 4; j++)
                if (ln[j] != 12'd0) begin t[n] = ln[j]; n++; end
            i = 0;
            k = 0;
            while (i < n) begin
                if (i + 1 < n && t[i] == t[i+1]) begin
                    o[k] = t[i] + t[i];
                    r.s  = r.s + 20'(t[i]) * 20'd2;
                    i    = i + 2;
                end else begin
                    o[k] = t[i];
                    i    = i + 1;
                end
                k++;
            end
            for (int j = 0; j < 4; j++) begin
                case (dir)
                    4'b0100: r.b[L][j]   = o[j];
                    4'b1000: r.b[L][3-j] = o[j];
                    4'b0001: r.b[j][L]   = o[j];
                    default: r.b[3-j][L] = o[j];
                endcase
            end
        end
        return r;
    endfunction

    function automatic brd_t row0(input int a, input int b, input int c, input int d);
        brd_t r = '0;
        r[0][0] = 12'(a);
        r[0][1] = 12'(b);
        r[0][2] = 12'(c);
        r[0][3] = 12'(d);
        return r;
    endfunction

    // The merge unit the controller drives.
    mres_t mres;
    always_comb begin
        mres            = ref_merge(merge_board_in, merge_dir);
        merge_board_out = mres.b;
        merge_score     = mres.s;
    end

    logic [15:0] lfsr_m;
    always @(posedge clk) begin
        if (rst) lfsr_m <= SEED;
        else     lfsr_m <= lfsr_step(lfsr_m);
    end

    // ---------------- scoreboard ----------------
    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    brd_t        board_m;
    logic [19:0] score_m;
    logic        won_m;
    logic        over_m;
    brd_t        init_board;

    task automatic push(input string tag, input logic [191:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [191:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %0h with nothing required", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input brd_t b);
        push("load_board", b);
        load_valid = 1'b1;
        load_board = b;
        step();
        load_valid = 1'b0;
        pop_check(board);
        board_m = b;
        won_m   = has_win(b);
        over_m  = is_dead(b);
        push("load_over", over_m);
        push("load_won", won_m);
        push("load_ready", !over_m);
        step();
        pop_check(game_over);
        pop_check(game_won);
        pop_check(move_ready);
    endtask

    task automatic do_move(input logic [3:0] dir);
        mres_t       r;
        logic [20:0] sum;
        logic [15:0] l2;
        brd_t        spawned;
        r  = ref_merge(board_m, dir);
        l2 = lfsr_step(lfsr_step(lfsr_m));
        push("pre_ready", 1'b1);
        pop_check(move_ready);
        push("acc_ready", 1'b0);
        push("apply_dir", dir);
        move_valid = 1'b1;
        move_dir   = dir;
        step();
        move_valid = 1'b0;
        pop_check(move_ready);
        pop_check(merge_dir);
        if (r.b == board_m) begin
            push("noop_board", board_m);
            push("noop_score", score_m);
            push("noop_ready", 1'b1);
            step();
            pop_check(board);
            pop_check(score);
            pop_check(move_ready);
        end else begin
            sum     = {1'b0, score_m} + {1'b0, r.s};
            score_m = sum[20] ? 20'hFFFFF : sum[19:0];
            push("e1_board", r.b);
            push("e1_score", score_m);
            step();
            pop_check(board);
            pop_check(score);
            spawned = ref_spawn(r.b, l2);
            board_m = spawned;
            push("e2_board", spawned);
            push("e2_ready", 1'b0);
            step();
            pop_check(board);
            pop_check(move_ready);
            won_m  = won_m | has_win(board_m);
            over_m = is_dead(board_m);
            push("e3_won", won_m);
            push("e3_over", over_m);
            push("e3_ready", !over_m);
            step();
            pop_check(game_won);
            pop_check(game_over);
            pop_check(move_ready);
        end
    endtask

    task automatic reset_and_init(input string tag);
        brd_t b0, b1;
        rst = 1'b1;
        step();
        step();
        push({tag, "_rst_board"}, '0);
        push({tag, "_rst_score"}, '0);
        push({tag, "_rst_won"}, 1'b0);
        push({tag, "_rst_over"}, 1'b0);
        push({tag, "_rst_ready"}, 1'b0);
        push({tag, "_rst_mdir"}, 4'b0000);
        pop_check(board);
        pop_check(score);
        pop_check(game_won);
        pop_check(game_over);
        pop_check(move_ready);
        pop_check(merge_dir);
        b0 = ref_spawn('0, lfsr_m);
        b1 = ref_spawn(b0, lfsr_step(lfsr_m));
        rst = 1'b0;
        push({tag, "_tile1"}, b0);
        push({tag, "_tile1_ready"}, 1'b0);
        step();
        pop_check(board);
        pop_check(move_ready);
        push({tag, "_tile2"}, b1);
        push({tag, "_init_ready"}, 1'b1);
        step();
        pop_check(board);
        pop_check(move_ready);
        board_m = b1;
        score_m = '0;
        won_m   = 1'b0;
        over_m  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        brd_t full;
        rst        = 1'b1;
        move_valid = 1'b0;
        move_dir   = 4'b0000;
        load_valid = 1'b0;
        load_board = '0;

        // Reset and two-tile init.
        reset_and_init("first");
        init_board = board_m;

        // Merge left: {2,2,4,0} -> {4,4,0,0}, score 4, one spawned tile.
        do_load(row0(2, 2, 4, 0));
        push("merge_left_model", row0(4, 4, 0, 0));
        pop_check(ref_merge(board_m, 4'b0100).b);
        do_move(4'b0100);
        push("merge_left_score", 20'd4);
        pop_check(score);

        // No-op left move, then a non-one-hot request.
        do_load(row0(2, 4, 8, 16));
        do_move(4'b0100);
        push("bad_dir_ready", 1'b1);
        push("bad_dir_mdir", 4'b0000);
        push("bad_dir_board", board_m);
        move_valid = 1'b1;
        move_dir   = 4'b0101;
        step();
        pop_check(move_ready);
        pop_check(merge_dir);
        step();
        move_valid = 1'b0;
        pop_check(board);

        // Win: 1024+1024 -> 2048, flag sticks across a further move.
        do_load(row0(1024, 1024, 0, 0));
        do_move(4'b0100);
        push("win_flag", 1'b1);
        pop_check(game_won);
        do_move(4'b0010);
        push("win_sticky", 1'b1);
        pop_check(game_won);

        // Game over on a dead board; moves ignored; load of empty board clears it.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                full[r][c] = (((r + c) % 2) == 0) ? 12'd2 : 12'd4;
        do_load(full);
        push("over_ready_1", 1'b0);
        push("over_ready_2", 1'b0);
        push("over_mdir", 4'b0000);
        push("over_board", full);
        move_valid = 1'b1;
        move_dir   = 4'b0100;
        step();
        pop_check(move_ready);
        step();
        step();
        pop_check(move_ready);
        pop_check(merge_dir);
        pop_check(board);
        move_valid = 1'b0;
        do_load('0);

        // Reset during SPAWN discards the move and replays the init sequence.
        do_load(row0(2, 2, 4, 0));
        move_valid = 1'b1;
        move_dir   = 4'b0100;
        step();
        move_valid = 1'b0;
        step();
        reset_and_init("mid");
        push("replay_board", init_board);
        pop_check(board);

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries never compared", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
